// File: rtl/stage_sequencer.sv
// Mission-level ascent sequencer: loads per-burn parameters into the velocity
// integrator, runs each burn to ignition_end, then coasts before the next burn.
module stage_sequencer #(
  parameter int unsigned N          = 64,
  parameter int unsigned ISP_1      = 263,
  parameter int unsigned ISP_2      = 421,
  parameter int unsigned ISP_3      = 421,
  parameter int unsigned PROP_1     = 2077000,
  parameter int unsigned PROP_2     = 456100,
  parameter int unsigned PROP_3     = 39136,
  parameter int unsigned PROP_4     = 83864,
  parameter int unsigned DRY_1      = 137000,
  parameter int unsigned DRY_2      = 40100,
  parameter int unsigned DRY_3      = 15200,
  parameter int unsigned PAYLOAD    = 27003,
  parameter int unsigned BURN_1     = 168,
  parameter int unsigned BURN_2     = 360,
  parameter int unsigned BURN_3     = 165,
  parameter int unsigned BURN_4     = 335,
  parameter int unsigned SEP_GAP    = 4,
  parameter int unsigned ARM_CYCLES = 1
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         launch,
  input  logic         hold,
  input  logic         ignition_end,
  output logic [N-1:0] specific_impulse,
  output logic [N-1:0] initial_weight,
  output logic [N-1:0] propellant_weight,
  output logic [N-1:0] burntime,
  output logic         engine_resetb,
  output logic [3:0]   stage_state,
  output logic         sep_pulse,
  output logic         leo_pulse,
  output logic         busy,
  output logic         mission_done
);

  localparam int unsigned CNT_W = 16;
  // Ignition mass of each burn: everything still attached at that point
  localparam int unsigned WEIGHT_4 = PROP_4 + DRY_3 + PAYLOAD;
  localparam int unsigned WEIGHT_3 = PROP_3 + WEIGHT_4;
  localparam int unsigned WEIGHT_2 = PROP_2 + DRY_2 + WEIGHT_3;
  localparam int unsigned WEIGHT_1 = PROP_1 + DRY_1 + WEIGHT_2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_BURN, S_COAST, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         burn_q, burn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [N-1:0]       isp_q, isp_d;
  logic [N-1:0]       weight_q, weight_d;
  logic [N-1:0]       prop_q, prop_d;
  logic [N-1:0]       btime_q, btime_d;
  logic               eng_q, eng_d;
  logic [3:0]         stage_q, stage_d;
  logic               sep_q, sep_d;
  logic               leo_q, leo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      burn_q   <= 2'd0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      isp_q    <= '0;
      weight_q <= '0;
      prop_q   <= '0;
      btime_q  <= N'(1);
      eng_q    <= 1'b0;
      stage_q  <= 4'd0;
      sep_q    <= 1'b0;
      leo_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      burn_q   <= burn_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      isp_q    <= isp_d;
      weight_q <= weight_d;
      prop_q   <= prop_d;
      btime_q  <= btime_d;
      eng_q    <= eng_d;
      stage_q  <= stage_d;
      sep_q    <= sep_d;
      leo_q    <= leo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    burn_d   = burn_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    isp_d    = isp_q;
    weight_d = weight_q;
    prop_d   = prop_q;
    btime_d  = btime_q;
    eng_d    = eng_q;
    stage_d  = stage_q;
    sep_d    = 1'b0;
    leo_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (launch && !hold) begin
          state_d = S_LOAD;
          burn_d  = 2'd0;
        end
      end
      S_LOAD: begin
        state_d = S_ARM;
        eng_d   = 1'b0;
        cnt_d   = CNT_W'(ARM_CYCLES - 1);
        stage_d = 4'(burn_q) + 4'd1;
        case (burn_q)
          2'd0: begin
            isp_d = N'(ISP_1); weight_d = N'(WEIGHT_1);
            prop_d = N'(PROP_1); btime_d = N'(BURN_1);
          end
          2'd1: begin
            isp_d = N'(ISP_2); weight_d = N'(WEIGHT_2);
            prop_d = N'(PROP_2); btime_d = N'(BURN_2);
          end
          2'd2: begin
            isp_d = N'(ISP_3); weight_d = N'(WEIGHT_3);
            prop_d = N'(PROP_3); btime_d = N'(BURN_3);
          end
          default: begin
            isp_d = N'(ISP_3); weight_d = N'(WEIGHT_4);
            prop_d = N'(PROP_4); btime_d = N'(BURN_4);
          end
        endcase
      end
      S_ARM: begin
        if (cnt_q == '0) begin
          state_d = S_BURN;
          eng_d   = 1'b1;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // First BURN cycle masks the integrator's stale ignition_end
      S_BURN: begin
        first_d = 1'b0;
        if (!first_q && ignition_end) begin
          state_d = S_COAST;
          eng_d   = 1'b0;
          cnt_d   = CNT_W'(SEP_GAP);
          sep_d   = (burn_q != 2'd2);
          leo_d   = (burn_q == 2'd2);
        end
      end
      S_COAST: begin
        if (!hold) begin
          if (cnt_q == '0) begin
            if (burn_q == 2'd3) begin
              state_d = S_DONE;
              stage_d = 4'd5;
            end else begin
              state_d = S_LOAD;
              burn_d  = burn_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        eng_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign specific_impulse  = isp_q;
  assign initial_weight    = weight_q;
  assign propellant_weight = prop_q;
  assign burntime          = btime_q;
  assign engine_resetb     = eng_q;
  assign stage_state       = stage_q;
  assign sep_pulse         = sep_q;
  assign leo_pulse         = leo_q;
  assign busy              = busy_q;
  assign mission_done      = done_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: expected stage/pulse events are queued
// as stimulus is applied and matched by a monitor as the DUT emits them.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        launch = 1'b0, hold = 1'b0, ign = 1'b0;
  logic        launch0 = 1'b0, hold0 = 1'b0, ign0 = 1'b0;
  logic [63:0] isp, iw, prop, bt, isp0, iw0, prop0, bt0;
  logic        eng, sep, leo, busy, done, eng0, sep0, leo0, busy0, done0;
  logic [3:0]  stage, stage0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int gap_meas = 0;
  int sep_n = 0;
  int leo_n = 0;
  logic [3:0] prev_stage = 4'd0;

  typedef struct {
    int          kind;   // 0 stage change, 1 sep, 2 leo
    int          stage;
    logic [63:0] iw, isp, prop, bt;
  } ev_t;
  ev_t exp_q[$];

  stage_sequencer u_dut (
    .clk(clk), .resetb(resetb), .launch(launch), .hold(hold), .ignition_end(ign),
    .specific_impulse(isp), .initial_weight(iw), .propellant_weight(prop), .burntime(bt),
    .engine_resetb(eng), .stage_state(stage), .sep_pulse(sep), .leo_pulse(leo),
    .busy(busy), .mission_done(done)
  );

  stage_sequencer #(.SEP_GAP(0)) u_gap0 (
    .clk(clk), .resetb(resetb), .launch(launch0), .hold(hold0), .ignition_end(ign0),
    .specific_impulse(isp0), .initial_weight(iw0), .propellant_weight(prop0), .burntime(bt0),
    .engine_resetb(eng0), .stage_state(stage0), .sep_pulse(sep0), .leo_pulse(leo0),
    .busy(busy0), .mission_done(done0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic ev_t cfg_ev(input int b, input int st);
    ev_t e;
    e.kind = 0;
    e.stage = st;
    case (b)
      1: begin e.iw = 64'd2875403; e.isp = 64'd263; e.prop = 64'd2077000; e.bt = 64'd168; end
      2: begin e.iw = 64'd661403;  e.isp = 64'd421; e.prop = 64'd456100;  e.bt = 64'd360; end
      3: begin e.iw = 64'd165203;  e.isp = 64'd421; e.prop = 64'd39136;   e.bt = 64'd165; end
      default: begin e.iw = 64'd126067; e.isp = 64'd421; e.prop = 64'd83864; e.bt = 64'd335; end
    endcase
    return e;
  endfunction

  function automatic ev_t pulse_ev(input int kind);
    ev_t e;
    e = cfg_ev(1, 0);
    e.kind = kind;
    return e;
  endfunction

  // Monitor: every stage change and every pulse cycle consumes one expectation
  always @(negedge clk) begin
    ev_t e;
    if (!resetb) begin
      prev_stage = 4'd0;
    end else begin
      if (stage != prev_stage) begin
        gap_meas = cyc - pulse_cyc;
        if (exp_q.size() == 0) check("unexpected_stage", 64'(stage), 64'(prev_stage));
        else begin
          e = exp_q.pop_front();
          check("ev_kind_stage", 64'(0), 64'(e.kind));
          check("stage_state", 64'(stage), 64'(e.stage));
          check("initial_weight", iw, e.iw);
          check("specific_impulse", isp, e.isp);
          check("propellant_weight", prop, e.prop);
          check("burntime", bt, e.bt);
        end
      end
      if (sep || leo) begin
        pulse_cyc = cyc;
        if (sep) sep_n++;
        if (leo) leo_n++;
        if (exp_q.size() == 0) check("unexpected_pulse", {62'd0, leo, sep}, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("pulse_kind", sep ? 64'd1 : 64'd2, 64'(e.kind));
          check("pulse_single", 64'(sep & leo), 64'd0);
        end
      end
      prev_stage = stage;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait: 0 main engine_resetb high, 1 main mission_done, 2 gap0 engine high
  task automatic wait_for(input int which, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      case (which)
        0: hit = (eng === 1'b1);
        1: hit = (done === 1'b1);
        default: hit = (eng0 === 1'b1);
      endcase
      if (!hit) tick(1);
    end
    if (!hit) check({"timeout_", tag}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    tick(2);
    resetb = 1'b1;
    tick(2);
  endtask

  // mode: 0 normal, 1 hold in first coast, 2 spurious ignition_end, 3 reset in burn 2
  task automatic run_mission(input int mode);
    sep_n = 0;
    leo_n = 0;
    if (mode == 2) begin
      ign = 1'b1;
      tick(3);
    end
    exp_q.push_back(cfg_ev(1, 1));
    launch = 1'b1;
    tick(1);
    launch = 1'b0;
    tick(1);
    check("b1_cfg_stage", 64'(stage), 64'd1);
    check("b1_eng_armed", 64'(eng), 64'd0);
    tick(1);
    check("b1_eng_rise", 64'(eng), 64'd1);
    for (int b = 1; b <= 4; b++) begin
      wait_for(0, "eng_rise");
      if (b == 2) check("coast_gap", 64'(gap_meas), (mode == 1) ? 64'd16 : 64'd6);
      if (mode == 3 && b == 2) begin
        tick(5);
        resetb = 1'b0;
        #1;
        check("rst_stage", 64'(stage), 64'd0);
        check("rst_weight", iw, 64'd0);
        check("rst_burntime", bt, 64'd1);
        check("rst_eng", 64'(eng), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        tick(2);
        resetb = 1'b1;
        tick(2);
        return;
      end
      if (mode == 2 && ign) begin
        tick(1);
        ign = 1'b0;
        check("spur_still_burn", 64'(eng), 64'd1);
        check("spur_stage", 64'(stage), 64'(b));
        tick(18);
      end else begin
        tick(19);
      end
      exp_q.push_back(pulse_ev((b == 3) ? 2 : 1));
      exp_q.push_back(cfg_ev(b, (b == 4) ? 5 : 0));
      if (b < 4) exp_q[exp_q.size()-1] = cfg_ev(b + 1, b + 1);
      ign = 1'b1;
      tick(1);
      ign = 1'b0;
      check("eng_off_after_burn", 64'(eng), 64'd0);
      if (mode == 1 && b == 1) begin
        hold = 1'b1;
        tick(10);
        hold = 1'b0;
      end
      if (mode == 2 && b == 1) ign = 1'b1;
    end
    wait_for(1, "done");
    tick(1);
    check("done_flag", 64'(done), 64'd1);
    check("done_stage", 64'(stage), 64'd5);
    check("done_busy", 64'(busy), 64'd0);
    check("done_eng", 64'(eng), 64'd0);
    check("sep_count", 64'(sep_n), 64'd3);
    check("leo_count", 64'(leo_n), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_low_burntime", bt, 64'd1);
    resetb = 1'b1;
    tick(2);
    check("reset_burntime", bt, 64'd1);
    check("reset_isp", isp, 64'd0);
    check("reset_weight", iw, 64'd0);
    check("reset_prop", prop, 64'd0);
    check("reset_eng", 64'(eng), 64'd0);
    check("reset_stage", 64'(stage), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // Full mission, then launch in DONE is ignored
    tick(6);
    run_mission(0);
    launch = 1'b1;
    tick(3);
    launch = 1'b0;
    check("done_ignores_launch", 64'(stage), 64'd5);
    check("done_sticky", 64'(done), 64'd1);

    // Launch under hold is dropped, then a mission with a held coast
    do_reset();
    hold = 1'b1;
    launch = 1'b1;
    tick(3);
    launch = 1'b0;
    tick(1);
    hold = 1'b0;
    tick(3);
    check("hold_launch_stage", 64'(stage), 64'd0);
    check("hold_launch_busy", 64'(busy), 64'd0);
    run_mission(1);

    // Spurious ignition_end
    do_reset();
    run_mission(2);

    // Reset during burn 2, then relaunch from burn 1
    do_reset();
    run_mission(3);
    run_mission(0);

    // SEP_GAP = 0 and launch during BURN
    do_reset();
    launch0 = 1'b1;
    tick(1);
    launch0 = 1'b0;
    wait_for(2, "gap0_eng");
    tick(3);
    launch0 = 1'b1;
    tick(3);
    launch0 = 1'b0;
    check("gap0_launch_in_burn_stage", 64'(stage0), 64'd1);
    check("gap0_launch_in_burn_eng", 64'(eng0), 64'd1);
    ign0 = 1'b1;
    tick(1);
    ign0 = 1'b0;
    check("gap0_sep", 64'(sep0), 64'd1);
    tick(1);
    check("gap0_load_stage", 64'(stage0), 64'd1);
    check("gap0_sep_clear", 64'(sep0), 64'd0);
    tick(1);
    check("gap0_next_stage", 64'(stage0), 64'd2);
    check("gap0_next_weight", iw0, 64'd661403);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
